// File: rtl/shotclock_display.sv
// Time-multiplexed 4-digit seven-segment driver for the shot clock: captures
// one frame of BCD digits per scan cycle, blanks a leading zero, blinks at expiry.
module shotclock_display #(
  parameter int unsigned BLINK_SCANS = 256,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic [3:0] s1,
  input  logic [3:0] s0,
  input  logic       zero,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [15:0] BLINK_LAST = 16'(BLINK_SCANS - 1);
  localparam logic [6:0]  SEG_BLANK  = 7'b1111111;

  logic [1:0]  idx_q, idx_d;
  logic [3:0]  cap_s1_q, cap_s1_d;
  logic [3:0]  cap_s0_q, cap_s0_d;
  logic        cap_zero_q, cap_zero_d;
  logic        frame_vld_q, frame_vld_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_on_q, blink_on_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q;
  logic        wrap;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b0000001;
      4'd1:    dec7 = 7'b1001111;
      4'd2:    dec7 = 7'b0010010;
      4'd3:    dec7 = 7'b0000110;
      4'd4:    dec7 = 7'b1001100;
      4'd5:    dec7 = 7'b0100100;
      4'd6:    dec7 = 7'b0100000;
      4'd7:    dec7 = 7'b0001111;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0000100;
      default: dec7 = 7'b1111110;
    endcase
  endfunction

  always_comb begin
    wrap        = scan_en && (idx_q == 2'd3);
    idx_d       = scan_en ? idx_q + 2'd1 : idx_q;
    cap_s1_d    = wrap ? s1   : cap_s1_q;
    cap_s0_d    = wrap ? s0   : cap_s0_q;
    cap_zero_d  = wrap ? zero : cap_zero_q;
    frame_vld_d = frame_vld_q | wrap;

    // Blink runs off the captured expiry flag, so a change arriving on the
    // wrap cycle only takes effect from the following clock.
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (!cap_zero_q) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (scan_en) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end

    // Dark until the first frame has been captured after reset.
    an_d = (blink_on_q && frame_vld_q) ? ~(4'b0001 << idx_q) : 4'b1111;

    seg_d = SEG_BLANK;
    if (frame_vld_q) begin
      case (idx_q)
        2'd0:    seg_d = dec7(cap_s0_q);
        2'd1:    seg_d = (LZ_BLANK && cap_s1_q == 4'd0 && cap_s0_q != 4'd0)
                         ? SEG_BLANK : dec7(cap_s1_q);
        default: seg_d = SEG_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= 2'd0;
      cap_s1_q    <= 4'd0;
      cap_s0_q    <= 4'd0;
      cap_zero_q  <= 1'b0;
      frame_vld_q <= 1'b0;
      blink_cnt_q <= 16'd0;
      blink_on_q  <= 1'b1;
      an_q        <= 4'b1111;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      idx_q       <= idx_d;
      cap_s1_q    <= cap_s1_d;
      cap_s0_q    <= cap_s0_d;
      cap_zero_q  <= cap_zero_d;
      frame_vld_q <= frame_vld_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= 1'b1;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_shotclock_display.sv
// Directed bench for shotclock_display: scan order, decode, leading-zero
// blanking, frame coherence, expiry blink, invalid BCD and mid-scan reset.
module tb_shotclock_display;

  logic       clk = 1'b0;
  logic       rst, scan_en, zero;
  logic [3:0] s1, s0;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shotclock_display #(.BLINK_SCANS(4), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .s1(s1), .s0(s0), .zero(zero),
    .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  shotclock_display #(.BLINK_SCANS(4), .LZ_BLANK(1'b0)) dut_nolz (
    .clk(clk), .rst(rst), .scan_en(scan_en), .s1(s1), .s0(s0), .zero(zero),
    .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle scan strobe followed by an idle gap (10 clk between strobes).
  task automatic pulse();
    scan_en = 1'b1;
    tick(1);
    scan_en = 1'b0;
    tick(9);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e);
    chk({tag, "_an"},  16'(an_a),  16'(an_e));
    chk({tag, "_seg"}, 16'(seg_a), 16'(seg_e));
  endtask

  logic [3:0] blink_exp [8];

  initial begin
    rst = 1'b1; scan_en = 1'b0; s1 = 4'd0; s0 = 4'd0; zero = 1'b0;
    blink_exp[0] = 4'b1101; blink_exp[1] = 4'b1011; blink_exp[2] = 4'b0111;
    blink_exp[3] = 4'b1111; blink_exp[4] = 4'b1111; blink_exp[5] = 4'b1111;
    blink_exp[6] = 4'b1111; blink_exp[7] = 4'b1110;

    // Reset held two cycles while scan_en toggles
    tick(1);
    scan_en = 1'b1; tick(1);
    scan_en = 1'b0; tick(1);
    chk_disp("reset", 4'b1111, 7'b1111111);
    chk("reset_dp", 16'(dp_a), 16'd1);
    chk("reset_idx", 16'(dut.idx_q), 16'd0);
    chk("reset_nolz_an", 16'(an_b), 16'hF);
    rst = 1'b0;

    // Value 24: dark before first capture, then scan order and decode
    s1 = 4'd2; s0 = 4'd4; zero = 1'b0;
    pulse();
    chk("pre_frame_an", 16'(an_a), 16'hF);
    pulse(); pulse(); pulse();
    chk("v24_idx_wrap", 16'(dut.idx_q), 16'd0);
    chk_disp("v24_ones", 4'b1110, 7'b1001100);
    scan_en = 1'b1; tick(1); scan_en = 1'b0;
    chk("v24_idx1", 16'(dut.idx_q), 16'd1);
    chk("v24_an_lag", 16'(an_a), 16'b1110);
    tick(1);
    chk_disp("v24_tens", 4'b1101, 7'b0010010);
    tick(8);
    pulse(); chk_disp("v24_slot2", 4'b1011, 7'b1111111);
    pulse(); chk_disp("v24_slot3", 4'b0111, 7'b1111111);
    pulse(); chk_disp("v24_ones2", 4'b1110, 7'b1001100);
    chk("v24_dp", 16'(dp_a), 16'd1);

    // Leading-zero blanking, 05
    s1 = 4'd0; s0 = 4'd5;
    pulse(); chk_disp("lz_oldframe_tens", 4'b1101, 7'b0010010);
    pulse(); pulse(); pulse();
    chk_disp("lz05_ones", 4'b1110, 7'b0100100);
    chk("lz05_ones_nolz", 16'(seg_b), 16'b0100100);
    pulse();
    chk_disp("lz05_tens", 4'b1101, 7'b1111111);
    chk("lz05_tens_nolz", 16'(seg_b), 16'b0000001);

    // 00 shows both digits
    s0 = 4'd0;
    pulse(); pulse(); pulse();
    chk_disp("z00_ones", 4'b1110, 7'b0000001);
    pulse();
    chk_disp("z00_tens", 4'b1101, 7'b0000001);

    // Frame coherence: mid-frame change of s0 stays hidden until the wrap
    s0 = 4'd4;
    pulse(); pulse(); pulse();
    chk_disp("coh_ones4", 4'b1110, 7'b1001100);
    s0 = 4'd3;
    tick(5);
    chk("coh_hold", 16'(seg_a), 16'b1001100);
    pulse(); chk_disp("coh_tens_lz", 4'b1101, 7'b1111111);
    pulse(); pulse();
    chk("coh_cap_s0", 16'(dut.cap_s0_q), 16'd4);
    pulse();
    chk_disp("coh_ones3", 4'b1110, 7'b0000110);

    // Expiry blink, BLINK_SCANS=4
    s0 = 4'd0; zero = 1'b1;
    pulse(); pulse(); pulse(); pulse();
    chk("blink_cap_zero", 16'(dut.cap_zero_q), 16'd1);
    chk_disp("blink_start", 4'b1110, 7'b0000001);
    for (int i = 0; i < 8; i++) begin
      pulse();
      chk($sformatf("blink_p%0d", i + 1), 16'(an_a), 16'(blink_exp[i]));
    end
    zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse();
      chk($sformatf("unblink_p%0d", i + 1), 16'(an_a), 16'(blink_exp[i]));
    end
    pulse();
    chk("unblink_cap_zero", 16'(dut.cap_zero_q), 16'd0);
    chk("unblink_on", 16'(dut.blink_on_q), 16'd1);
    chk_disp("unblink_visible", 4'b1110, 7'b0000001);

    // Invalid BCD shows a dash
    s1 = 4'hC;
    pulse(); pulse(); pulse(); pulse();
    pulse();
    chk_disp("bad_tens", 4'b1101, 7'b1111110);
    chk("bad_tens_nolz", 16'(seg_b), 16'b1111110);

    // Reset with scan_en high at idx 2: no advance, display dark
    pulse();
    chk("pre_rst_idx", 16'(dut.idx_q), 16'd2);
    rst = 1'b1; scan_en = 1'b1;
    tick(1);
    chk("rst_idx", 16'(dut.idx_q), 16'd0);
    chk_disp("rst_mid", 4'b1111, 7'b1111111);
    chk("rst_cap_s1", 16'(dut.cap_s1_q), 16'd0);
    rst = 1'b0; scan_en = 1'b0;
    tick(2);
    chk("post_rst_dark", 16'(an_a), 16'hF);
    chk("post_rst_dp", 16'(dp_a), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shotclock_display.md
Name: shotclock_display

Overview:
- Time-multiplexed 4-digit seven-segment driver for the shot clock.
- Consumes the BCD seconds digits (s1, s0) and expiry flag (zero) from the countdown counter, plus the scan strobe from the clock divider.
- Drives the board's active-low anodes, segments and decimal point.
- Adds frame-coherent input capture, leading-zero blanking, invalid-digit indication and blinking at expiry.

Parameters:
- BLINK_SCANS, default 256: scan_en pulses per blink half-period while expired; legal range 2..65535.
- LZ_BLANK, default 1: 1 = blank tens digit when it is 0 and the value is nonzero; 0 = always show the tens digit.

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  synchronous, active-high reset
- scan_en  input  1  single-cycle digit-advance strobe from the divider
- s1  input  4  tens digit, BCD
- s0  input  4  ones digit, BCD
- zero  input  1  countdown expired flag
- an  output  4  anode enables, active-low; an[0] = rightmost digit
- seg  output  7  segments, active-low; seg[6]=a … seg[0]=g
- dp  output  1  decimal point, active-low

Behaviour:
- One clock, clk. Reset is synchronous, active-high (rst). All state and outputs are registered.
- **Reset values:**
  - an=4'b1111, seg=7'b1111111, dp=1.
  - idx=0, cap_s1=0, cap_s0=0, cap_zero=0.
  - blink_cnt=0, blink_on=1.
- **Scan index:**
  - 2-bit idx advances on each cycle with scan_en=1: 0→1→2→3→0, wrapping at 3.
  - idx holds when scan_en=0.
- **Frame capture:**
  - In the cycle where scan_en=1 and idx=3 (the wrap), cap_s1/cap_s0/cap_zero load from s1/s0/zero.
  - Input changes mid-frame are therefore never visible until the next frame.
- **Output timing:** an/seg are registered from the current idx and captured values, so they change exactly 1 clk after idx or the captures change.
- **Digit content by idx:**
  - idx 3 and 2: blank; an bit driven low but seg=7'b1111111.
  - idx 1: tens digit; blank when LZ_BLANK=1, cap_s1=0 and cap_s0≠0.
  - idx 0: ones digit, never leading-blanked.
- **Anodes:**
  - an = ~(4'b0001 << idx) when blink_on=1.
  - an = 4'b1111 when blink_on=0.
- **Decoder:**
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Any value 10–15 displays dash 7'b1111110.
- **dp:** constant 1 (off) after reset.
- **Blink:**
  - While cap_zero=0: blink_cnt=0 and blink_on=1.
  - While cap_zero=1, each scan_en increments blink_cnt. At BLINK_SCANS-1, blink_cnt wraps to 0 and blink_on toggles.
  - A 0→1 transition of cap_zero starts with blink_on=1 and a full visible half-period.
  - A 1→0 transition forces blink_on=1 on the next clock.
  - In the cycle where scan_en=1, idx=3 and zero changes, the blink logic uses the old cap_zero for that cycle.
- **Reset mid-operation:** rst overrides scan_en on the same edge. All state and outputs take reset values at the next clk edge, and the display is dark until the first captured frame is scanned.

Test Plan:
- **Reset:** assert rst 2 cycles with scan_en toggling → an=1111, seg=1111111, dp=1, idx=0.
- **Value 24:**
  - Apply s1=2, s0=4, zero=0 and pulse scan_en every 10 clk for 8 pulses.
  - After the first wrap, anode sequence repeats 1110,1101,1011,0111.
  - seg=0010010 when an=1101; seg=1001100 when an=1110; seg=1111111 for an=1011/0111. Each update occurs 1 clk after the scan_en pulse.
- **Leading-zero blanking:**
  - s1=0, s0=5, LZ_BLANK=1 → tens slot seg=1111111, ones slot seg=0100100.
  - Same with LZ_BLANK=0 → tens slot seg=0000001.
  - s1=0, s0=0 → both slots show 0000001.
- **Frame coherence:** change s0 from 4 to 3 while idx=1 → ones slot keeps 1001100 until after the next idx 3→0 wrap, then shows 0000110.
- **Expiry blink with BLINK_SCANS=4:**
  - Set s1=0, s0=0, zero=1 → after capture, 4 scan pulses visible, then 4 pulses with an=1111, repeating.
  - Drop zero → blinking stops and the display is visible after the next capture.
- **Invalid BCD and reset:**
  - s1=4'hC → tens slot seg=1111110.
  - Assert rst while idx=2 and scan_en=1 → next edge gives an=1111 and idx=0, with no advance.
